proj_kmer_extractor: RTL

Streaming k-mer producer that sits in front of `proj_hasher`. It accepts one 2-bit base per cycle over a valid/ready handshake and maintains a sliding window of the last `KMER_LEN` bases. For every window position it emits a zero-extended k-mer word, ready to drive the hasher's `kmer` input. Ambiguous bases ('N') restart the window, and sequence boundaries are carried through so downstream min-selection can close each signature.

---
 rtl/proj_pkg.sv | 17 +
 rtl/proj_kmer_extractor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/proj_pkg.sv
// Shared constants and types for the sequence-sketching pipeline.
package proj_pkg;

    localparam int KMER_LEN                = 4;
    localparam int BASE_LEN                = 2;
    localparam int HASHER_SORTER_SIGNATURE = 32;
    localparam int KMER_POS_BITS           = 16;

    // Two-bit nucleotide codes
    localparam logic [BASE_LEN-1:0] BASE_A = 2'd0;
    localparam logic [BASE_LEN-1:0] BASE_C = 2'd1;
    localparam logic [BASE_LEN-1:0] BASE_G = 2'd2;
    localparam logic [BASE_LEN-1:0] BASE_T = 2'd3;

    typedef logic [HASHER_SORTER_SIGNATURE-1:0] kmer_word_t;

endpackage

// File: rtl/proj_kmer_extractor.sv
// Streaming k-mer producer: slides a KMER_LEN-base window over the input
// bases and emits one zero-extended k-mer word per full window position.
// N bases restart the window; sequence ends are forwarded as kmer_last and
// a registered seq_done pulse.
module proj_kmer_extractor
    import proj_pkg::*;
#(
    parameter int KMER_LEN         = proj_pkg::KMER_LEN,
    parameter int DATA_BITS        = proj_pkg::BASE_LEN,
    parameter int HASHER_DATA_BITS = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int POS_BITS         = proj_pkg::KMER_POS_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        base_valid,
    output logic                        base_ready,
    input  logic [DATA_BITS-1:0]        base_data,
    input  logic                        base_n,
    input  logic                        base_last,
    output logic                        kmer_valid,
    input  logic                        kmer_ready,
    output logic [HASHER_DATA_BITS-1:0] kmer,
    output logic [POS_BITS-1:0]         kmer_pos,
    output logic                        kmer_last,
    output logic                        seq_done
);

    localparam int WIN_W  = KMER_LEN * DATA_BITS;
    localparam int FILL_W = $clog2(KMER_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(KMER_LEN);

    // Reject parameter sets whose window cannot fit the hasher word
    generate
        if ((KMER_LEN < 1) || (KMER_LEN * DATA_BITS > HASHER_DATA_BITS)) begin : g_param_err
            $error("proj_kmer_extractor: KMER_LEN*DATA_BITS must fit HASHER_DATA_BITS and KMER_LEN >= 1");
        end
    endgenerate

    logic [WIN_W-1:0]            window_q,     window_d;
    logic [FILL_W-1:0]           fill_q,       fill_d;
    logic [POS_BITS-1:0]         base_pos_q,   base_pos_d;
    logic                        kmer_valid_q, kmer_valid_d;
    logic [HASHER_DATA_BITS-1:0] kmer_q,       kmer_d;
    logic [POS_BITS-1:0]         kmer_pos_q,   kmer_pos_d;
    logic                        kmer_last_q,  kmer_last_d;
    logic                        seq_done_q,   seq_done_d;

    logic                        xfer;
    logic                        emit;
    logic [WIN_W+DATA_BITS-1:0]  shifted;

    // Single output slot: a new base can enter whenever the slot is empty or draining
    assign base_ready = !kmer_valid_q || kmer_ready;

    // Next-state: window shift, fill saturation, position tracking and slot load
    always_comb begin
        xfer         = base_valid && base_ready;
        emit         = 1'b0;
        shifted      = {window_q, base_data};
        window_d     = window_q;
        fill_d       = fill_q;
        base_pos_d   = base_pos_q;
        kmer_valid_d = kmer_valid_q;
        kmer_d       = kmer_q;
        kmer_pos_d   = kmer_pos_q;
        kmer_last_d  = kmer_last_q;
        seq_done_d   = 1'b0;

        if (kmer_valid_q && kmer_ready) begin
            kmer_valid_d = 1'b0;
        end

        if (xfer) begin
            base_pos_d = base_pos_q + POS_BITS'(1);
            if (base_n) begin
                // Ambiguous base: window contents become meaningless, restart filling
                fill_d = '0;
            end else begin
                window_d = shifted[WIN_W-1:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                emit = (fill_d == FILL_MAX);
            end

            if (emit) begin
                // A new emit overwrites the slot even if it is draining this cycle
                kmer_valid_d = 1'b1;
                kmer_d       = HASHER_DATA_BITS'(window_d);
                kmer_pos_d   = base_pos_q - POS_BITS'(KMER_LEN - 1);
                kmer_last_d  = base_last;
            end

            if (base_last) begin
                fill_d     = '0;
                base_pos_d = '0;
                seq_done_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_q     <= '0;
            fill_q       <= '0;
            base_pos_q   <= '0;
            kmer_valid_q <= 1'b0;
            kmer_q       <= '0;
            kmer_pos_q   <= '0;
            kmer_last_q  <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            window_q     <= window_d;
            fill_q       <= fill_d;
            base_pos_q   <= base_pos_d;
            kmer_valid_q <= kmer_valid_d;
            kmer_q       <= kmer_d;
            kmer_pos_q   <= kmer_pos_d;
            kmer_last_q  <= kmer_last_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign kmer_valid = kmer_valid_q;
    assign kmer       = kmer_q;
    assign kmer_pos   = kmer_pos_q;
    assign kmer_last  = kmer_last_q;
    assign seq_done   = seq_done_q;

endmodule
